// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings, FSM states, multi-cycle defaults and the register-match helper.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int CNT_W_DEF      = 6;

  typedef enum logic [0:0] {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_e;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic we, input logic [4:0] wreg, input logic [4:0] r);
    return we && (wreg != 5'd0) && (wreg == r);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_is_muldiv;
  logic        id_is_div;
  logic        id_branch_taken;
  logic        exe_rf_we;
  logic [4:0]  exe_wreg;
  logic        exe_is_load;
  logic        mem_rf_we;
  logic [4:0]  mem_wreg;

  logic        pc_we;
  logic        fd_we;
  logic        fd_flush;
  logic        de_we;
  logic        de_bubble;
  logic        em_bubble;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        muldiv_busy;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_is_muldiv, id_is_div,
           id_branch_taken, exe_rf_we, exe_wreg, exe_is_load, mem_rf_we, mem_wreg,
    input  pc_we, fd_we, fd_flush, de_we, de_bubble, em_bubble,
           fwd_a_sel, fwd_b_sel, muldiv_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_is_muldiv, id_is_div,
           id_branch_taken, exe_rf_we, exe_wreg, exe_is_load, mem_rf_we, mem_wreg,
    output pc_we, fd_we, fd_flush, de_we, de_bubble, em_bubble,
           fwd_a_sel, fwd_b_sel, muldiv_busy, stall_cycles
  );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Per-operand dependency check: forwarding select for one source register and
// a flag telling the controller the operand depends on the EXE instruction.
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic       i_reg_used,
  input  logic [4:0] i_reg,
  input  logic       i_exe_rf_we,
  input  logic [4:0] i_exe_wreg,
  input  logic       i_exe_is_load,
  input  logic       i_mem_rf_we,
  input  logic [4:0] i_mem_wreg,
  output logic       o_exe_hit,
  output logic [1:0] o_sel
);

  logic w_exe_match;
  logic w_mem_match;

  assign w_exe_match = i_reg_used && reg_match(i_exe_rf_we, i_exe_wreg, i_reg);
  assign w_mem_match = i_reg_used && reg_match(i_mem_rf_we, i_mem_wreg, i_reg);
  assign o_exe_hit   = w_exe_match;

  // Youngest producer wins; a load in EXE has no data yet, so it never feeds EXE/MEM Z.
  always_comb begin
    o_sel = FWD_RF;
    if (w_exe_match && !i_exe_is_load) begin
      o_sel = FWD_EXE;
    end else if (w_mem_match) begin
      o_sel = FWD_MEM;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: stage write enables,
// bubbles, branch flush, operand forwarding and multi-cycle MUL/DIV sequencing.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  hz_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_stall_cycles;

  logic             w_rs_exe_hit;
  logic             w_rt_exe_hit;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_busy;
  logic             w_load_use;
  logic             w_issue;
  logic [CNT_W-1:0] w_cnt_load;
  logic             w_pc_we;
  logic             w_fd_we;
  logic             w_de_we;
  logic             w_de_bubble;
  logic             w_em_bubble;
  logic             w_fd_flush;

  pipe_fwd_unit u_fwd_rs (
    .i_reg_used    (hz.id_rs_used),
    .i_reg         (hz.id_rs),
    .i_exe_rf_we   (hz.exe_rf_we),
    .i_exe_wreg    (hz.exe_wreg),
    .i_exe_is_load (hz.exe_is_load),
    .i_mem_rf_we   (hz.mem_rf_we),
    .i_mem_wreg    (hz.mem_wreg),
    .o_exe_hit     (w_rs_exe_hit),
    .o_sel         (w_fwd_a)
  );

  pipe_fwd_unit u_fwd_rt (
    .i_reg_used    (hz.id_rt_used),
    .i_reg         (hz.id_rt),
    .i_exe_rf_we   (hz.exe_rf_we),
    .i_exe_wreg    (hz.exe_wreg),
    .i_exe_is_load (hz.exe_is_load),
    .i_mem_rf_we   (hz.mem_rf_we),
    .i_mem_wreg    (hz.mem_wreg),
    .o_exe_hit     (w_rt_exe_hit),
    .o_sel         (w_fwd_b)
  );

  assign w_busy     = (r_state == HZ_BUSY);
  assign w_load_use = hz.exe_is_load && (w_rs_exe_hit || w_rt_exe_hit);
  assign w_cnt_load = hz.id_is_div ? DIV_LOAD : MUL_LOAD;
  // A MUL/DIV only counts as issued when it really enters EXE this cycle.
  assign w_issue    = w_de_we && !w_de_bubble && hz.id_is_muldiv;

  // Stage control, in priority order: reset, busy EXE, load-use, branch flush, normal flow.
  always_comb begin
    w_pc_we     = 1'b1;
    w_fd_we     = 1'b1;
    w_de_we     = 1'b1;
    w_de_bubble = 1'b0;
    w_em_bubble = 1'b0;
    w_fd_flush  = 1'b0;
    if (rst) begin
      w_pc_we     = 1'b0;
      w_fd_we     = 1'b0;
      w_de_we     = 1'b0;
      w_de_bubble = 1'b1;
      w_em_bubble = 1'b1;
    end else if (w_busy) begin
      w_pc_we     = 1'b0;
      w_fd_we     = 1'b0;
      w_de_we     = 1'b0;
      w_em_bubble = 1'b1;
    end else if (w_load_use) begin
      w_pc_we     = 1'b0;
      w_fd_we     = 1'b0;
      w_de_bubble = 1'b1;
    end else if (hz.id_branch_taken) begin
      w_fd_flush  = 1'b1;
    end else begin
      w_fd_flush  = 1'b0;
    end
  end

  // MUL/DIV occupancy FSM; a one-cycle op never leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HZ_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        HZ_IDLE: begin
          if (w_issue && (w_cnt_load != CNT_ZERO)) begin
            r_state <= HZ_BUSY;
            r_cnt   <= w_cnt_load;
          end else begin
            r_state <= HZ_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        HZ_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= HZ_IDLE;
          end else begin
            r_state <= HZ_BUSY;
          end
        end
        default: begin
          r_state <= HZ_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
    end else if (!w_pc_we && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign hz.pc_we        = w_pc_we;
  assign hz.fd_we        = w_fd_we;
  assign hz.de_we        = w_de_we;
  assign hz.de_bubble    = w_de_bubble;
  assign hz.em_bubble    = w_em_bubble;
  assign hz.fd_flush     = w_fd_flush;
  assign hz.fwd_a_sel    = rst ? FWD_RF : w_fwd_a;
  assign hz.fwd_b_sel    = rst ? FWD_RF : w_fwd_b;
  assign hz.muldiv_busy  = w_busy;
  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios on a MUL=1/DIV=32
// instance plus a randomized run of two instances against a cycle-level model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_stall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz0 ();
  pipe_hazard_ctrl_if hz1 ();

  pipe_hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(32), .CNT_W(6)) dut0 (.clk(clk), .rst(rst), .hz(hz0));
  pipe_hazard_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(2),  .CNT_W(6)) dut1 (.clk(clk), .rst(rst), .hz(hz1));

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic rs_u, input logic rt_u,
                        input logic md, input logic dv, input logic br,
                        input logic e_we, input logic [4:0] e_wr, input logic e_ld,
                        input logic m_we, input logic [4:0] m_wr);
    hz0.id_rs = rs;  hz0.id_rt = rt;  hz0.id_rs_used = rs_u;  hz0.id_rt_used = rt_u;
    hz0.id_is_muldiv = md;  hz0.id_is_div = dv;  hz0.id_branch_taken = br;
    hz0.exe_rf_we = e_we;  hz0.exe_wreg = e_wr;  hz0.exe_is_load = e_ld;
    hz0.mem_rf_we = m_we;  hz0.mem_wreg = m_wr;
    hz1.id_rs = rs;  hz1.id_rt = rt;  hz1.id_rs_used = rs_u;  hz1.id_rt_used = rt_u;
    hz1.id_is_muldiv = md;  hz1.id_is_div = dv;  hz1.id_branch_taken = br;
    hz1.exe_rf_we = e_we;  hz1.exe_wreg = e_wr;  hz1.exe_is_load = e_ld;
    hz1.mem_rf_we = m_we;  hz1.mem_wreg = m_wr;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 5'd5);
    #1;
    checks++; if (hz0.pc_we !== 1'b0) begin failures++; $display("FAIL rst_pc_we got=%0b want=0", hz0.pc_we); end
    checks++; if (hz0.fd_we !== 1'b0) begin failures++; $display("FAIL rst_fd_we got=%0b want=0", hz0.fd_we); end
    checks++; if (hz0.de_we !== 1'b0) begin failures++; $display("FAIL rst_de_we got=%0b want=0", hz0.de_we); end
    checks++; if (hz0.de_bubble !== 1'b1) begin failures++; $display("FAIL rst_de_bubble got=%0b want=1", hz0.de_bubble); end
    checks++; if (hz0.em_bubble !== 1'b1) begin failures++; $display("FAIL rst_em_bubble got=%0b want=1", hz0.em_bubble); end
    checks++; if (hz0.fd_flush !== 1'b0) begin failures++; $display("FAIL rst_fd_flush got=%0b want=0", hz0.fd_flush); end
    checks++; if (hz0.fwd_a_sel !== 2'b00) begin failures++; $display("FAIL rst_fwd_a got=%0b want=00", hz0.fwd_a_sel); end
    checks++; if (hz0.fwd_b_sel !== 2'b00) begin failures++; $display("FAIL rst_fwd_b got=%0b want=00", hz0.fwd_b_sel); end
    repeat (2) @(negedge clk);
    checks++; if (hz0.muldiv_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b want=0", hz0.muldiv_busy); end
    checks++; if (hz0.stall_cycles !== 32'd0) begin failures++; $display("FAIL rst_stall got=%0h want=0", hz0.stall_cycles); end
    rst = 1'b0;
    idle();
    #1;
    checks++; if (hz0.pc_we !== 1'b1) begin failures++; $display("FAIL rel_pc_we got=%0b want=1", hz0.pc_we); end
    checks++; if (hz0.em_bubble !== 1'b0) begin failures++; $display("FAIL rel_em_bubble got=%0b want=0", hz0.em_bubble); end
    exp_stall = 32'd0;
  endtask

  task automatic test_load_use();
    // lw $2 in EXE, add using $2 in ID, plus a taken branch that must be ignored
    @(negedge clk);
    set_in(5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.pc_we !== 1'b0) begin failures++; $display("FAIL lu_pc_we got=%0b want=0", hz0.pc_we); end
    checks++; if (hz0.fd_we !== 1'b0) begin failures++; $display("FAIL lu_fd_we got=%0b want=0", hz0.fd_we); end
    checks++; if (hz0.de_we !== 1'b1) begin failures++; $display("FAIL lu_de_we got=%0b want=1", hz0.de_we); end
    checks++; if (hz0.de_bubble !== 1'b1) begin failures++; $display("FAIL lu_de_bubble got=%0b want=1", hz0.de_bubble); end
    checks++; if (hz0.fd_flush !== 1'b0) begin failures++; $display("FAIL lu_fd_flush got=%0b want=0", hz0.fd_flush); end
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    set_in(5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2);
    #1;
    checks++; if (hz0.fwd_a_sel !== 2'b10) begin failures++; $display("FAIL lu_next_fwd_a got=%0b want=10", hz0.fwd_a_sel); end
    checks++; if (hz0.pc_we !== 1'b1) begin failures++; $display("FAIL lu_next_pc_we got=%0b want=1", hz0.pc_we); end
    checks++; if (hz0.stall_cycles !== exp_stall) begin failures++; $display("FAIL lu_stall got=%0d want=%0d", hz0.stall_cycles, exp_stall); end
    @(negedge clk);
    set_in(5'd9, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.pc_we !== 1'b0) begin failures++; $display("FAIL lu_rt_pc_we got=%0b want=0", hz0.pc_we); end
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    set_in(5'd9, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.pc_we !== 1'b1) begin failures++; $display("FAIL lu_unused_pc_we got=%0b want=1", hz0.pc_we); end
    checks++; if (hz0.stall_cycles !== exp_stall) begin failures++; $display("FAIL lu_rt_stall got=%0d want=%0d", hz0.stall_cycles, exp_stall); end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 5'd5);
    #1;
    checks++; if (hz0.fwd_a_sel !== 2'b01) begin failures++; $display("FAIL fwd_exe_a got=%0b want=01", hz0.fwd_a_sel); end
    checks++; if (hz0.fwd_b_sel !== 2'b01) begin failures++; $display("FAIL fwd_exe_b got=%0b want=01", hz0.fwd_b_sel); end
    @(negedge clk);
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd5);
    #1;
    checks++; if (hz0.fwd_a_sel !== 2'b10) begin failures++; $display("FAIL fwd_mem_a got=%0b want=10", hz0.fwd_a_sel); end
    checks++; if (hz0.fwd_b_sel !== 2'b10) begin failures++; $display("FAIL fwd_mem_b got=%0b want=10", hz0.fwd_b_sel); end
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0);
    #1;
    checks++; if (hz0.fwd_a_sel !== 2'b00) begin failures++; $display("FAIL fwd_r0_a got=%0b want=00", hz0.fwd_a_sel); end
    checks++; if (hz0.fwd_b_sel !== 2'b00) begin failures++; $display("FAIL fwd_r0_b got=%0b want=00", hz0.fwd_b_sel); end
    @(negedge clk);
    set_in(5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6);
    #1;
    checks++; if (hz0.fwd_a_sel !== 2'b10) begin failures++; $display("FAIL fwd_used_a got=%0b want=10", hz0.fwd_a_sel); end
    checks++; if (hz0.fwd_b_sel !== 2'b00) begin failures++; $display("FAIL fwd_unused_b got=%0b want=00", hz0.fwd_b_sel); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.fd_flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%0b want=1", hz0.fd_flush); end
    checks++; if ({hz0.pc_we, hz0.fd_we, hz0.de_we} !== 3'b111) begin failures++; $display("FAIL br_we got=%0b want=111", {hz0.pc_we, hz0.fd_we, hz0.de_we}); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (hz0.fd_flush !== 1'b0) begin failures++; $display("FAIL br_off_flush got=%0b want=0", hz0.fd_flush); end
    @(negedge clk);
    set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.fd_flush !== 1'b0) begin failures++; $display("FAIL br_lu_flush got=%0b want=0", hz0.fd_flush); end
    checks++; if (hz0.pc_we !== 1'b0) begin failures++; $display("FAIL br_lu_pc_we got=%0b want=0", hz0.pc_we); end
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    idle();
    #1;
    checks++; if (hz0.stall_cycles !== exp_stall) begin failures++; $display("FAIL br_stall got=%0d want=%0d", hz0.stall_cycles, exp_stall); end
  endtask

  task automatic test_div();
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.muldiv_busy !== 1'b0) begin failures++; $display("FAIL div_issue_busy got=%0b want=0", hz0.muldiv_busy); end
    checks++; if (hz0.pc_we !== 1'b1) begin failures++; $display("FAIL div_issue_pc_we got=%0b want=1", hz0.pc_we); end
    for (int b = 1; b <= 31; b++) begin
      @(negedge clk);
      // a load-use and a taken branch are presented throughout; BUSY must dominate
      set_in(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
      #1;
      checks++; if (hz0.muldiv_busy !== 1'b1) begin failures++; $display("FAIL div_busy[%0d] got=%0b want=1", b, hz0.muldiv_busy); end
      checks++; if ({hz0.pc_we, hz0.fd_we, hz0.de_we} !== 3'b000) begin failures++; $display("FAIL div_we[%0d] got=%0b want=000", b, {hz0.pc_we, hz0.fd_we, hz0.de_we}); end
      checks++; if (hz0.em_bubble !== 1'b1) begin failures++; $display("FAIL div_em_bubble[%0d] got=%0b want=1", b, hz0.em_bubble); end
      checks++; if (hz0.fd_flush !== 1'b0) begin failures++; $display("FAIL div_flush[%0d] got=%0b want=0", b, hz0.fd_flush); end
    end
    exp_stall = exp_stall + 32'd31;
    @(negedge clk);
    idle();
    #1;
    checks++; if (hz0.muldiv_busy !== 1'b0) begin failures++; $display("FAIL div_done_busy got=%0b want=0", hz0.muldiv_busy); end
    checks++; if (hz0.pc_we !== 1'b1) begin failures++; $display("FAIL div_done_pc_we got=%0b want=1", hz0.pc_we); end
    checks++; if (hz0.em_bubble !== 1'b0) begin failures++; $display("FAIL div_done_em_bubble got=%0b want=0", hz0.em_bubble); end
    checks++; if (hz0.stall_cycles !== exp_stall) begin failures++; $display("FAIL div_stall got=%0d want=%0d", hz0.stall_cycles, exp_stall); end
  endtask

  task automatic test_mul_single();
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.pc_we !== 1'b1) begin failures++; $display("FAIL mul_issue_pc_we got=%0b want=1", hz0.pc_we); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (hz0.muldiv_busy !== 1'b0) begin failures++; $display("FAIL mul1_busy got=%0b want=0", hz0.muldiv_busy); end
    checks++; if (hz0.pc_we !== 1'b1) begin failures++; $display("FAIL mul1_pc_we got=%0b want=1", hz0.pc_we); end
    checks++; if (hz1.muldiv_busy !== 1'b1) begin failures++; $display("FAIL mul3_busy1 got=%0b want=1", hz1.muldiv_busy); end
    @(negedge clk);
    #1;
    checks++; if (hz1.muldiv_busy !== 1'b1) begin failures++; $display("FAIL mul3_busy2 got=%0b want=1", hz1.muldiv_busy); end
    @(negedge clk);
    #1;
    checks++; if (hz1.muldiv_busy !== 1'b0) begin failures++; $display("FAIL mul3_done got=%0b want=0", hz1.muldiv_busy); end
    checks++; if (hz1.pc_we !== 1'b1) begin failures++; $display("FAIL mul3_done_pc_we got=%0b want=1", hz1.pc_we); end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    repeat (22) begin
      @(negedge clk);
      idle();
    end
    // 21 busy edges have passed, so the remaining count is 10
    #1;
    checks++; if (hz0.muldiv_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0b want=1", hz0.muldiv_busy); end
    checks++; if (hz0.stall_cycles !== exp_stall + 32'd21) begin failures++; $display("FAIL mid_stall got=%0d want=%0d", hz0.stall_cycles, exp_stall + 32'd21); end
    rst = 1'b1;
    #1;
    checks++; if (hz0.muldiv_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b want=0", hz0.muldiv_busy); end
    checks++; if (hz0.stall_cycles !== 32'd0) begin failures++; $display("FAIL mid_rst_stall got=%0d want=0", hz0.stall_cycles); end
    checks++; if (hz0.pc_we !== 1'b0) begin failures++; $display("FAIL mid_rst_pc_we got=%0b want=0", hz0.pc_we); end
    exp_stall = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({hz0.pc_we, hz0.fd_we, hz0.de_we} !== 3'b111) begin failures++; $display("FAIL mid_rel_we got=%0b want=111", {hz0.pc_we, hz0.fd_we, hz0.de_we}); end
    @(negedge clk);
    #1;
    checks++; if (hz0.muldiv_busy !== 1'b0) begin failures++; $display("FAIL mid_rel_busy got=%0b want=0", hz0.muldiv_busy); end
    checks++; if (hz0.stall_cycles !== 32'd0) begin failures++; $display("FAIL mid_rel_stall got=%0d want=0", hz0.stall_cycles); end
  endtask

  task automatic test_saturation();
    longint m;
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    force dut0.r_stall_cycles = 32'hFFFF_FFF0;
    #1;
    release dut0.r_stall_cycles;
    for (int b = 1; b <= 31; b++) begin
      @(negedge clk);
      idle();
      #1;
      m = 64'h0000_0000_FFFF_FFF0 + longint'(b - 1);
      if (m > 64'h0000_0000_FFFF_FFFF) m = 64'h0000_0000_FFFF_FFFF;
      checks++; if (hz0.stall_cycles !== 32'(m)) begin failures++; $display("FAIL sat_stall[%0d] got=%0h want=%0h", b, hz0.stall_cycles, 32'(m)); end
    end
    @(negedge clk);
    set_in(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (hz0.stall_cycles !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_max got=%0h want=ffffffff", hz0.stall_cycles); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (hz0.stall_cycles !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold got=%0h want=ffffffff", hz0.stall_cycles); end
  endtask

  task automatic test_random();
    int          left [2];
    longint      cnt [2];
    int          muln [2];
    int          divn [2];
    logic [4:0]  rs, rt, ewr, mwr;
    logic        rsu, rtu, md, dv, br, ewe, eld, mwe, lu, stalled;
    logic [1:0]  fa, fb;
    logic [10:0] ov, ev, mask;
    logic [31:0] sv;
    muln[0] = 1;  muln[1] = 3;  divn[0] = 32;  divn[1] = 2;
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      left[d] = 0;
      cnt[d]  = 0;
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rs  = 5'($urandom_range(0, 3));  rt  = 5'($urandom_range(0, 3));
      ewr = 5'($urandom_range(0, 3));  mwr = 5'($urandom_range(0, 3));
      rsu = 1'($urandom_range(0, 1));  rtu = 1'($urandom_range(0, 1));
      ewe = 1'($urandom_range(0, 1));  mwe = 1'($urandom_range(0, 1));
      eld = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 3) == 0);
      md  = ($urandom_range(0, 5) == 0);
      dv  = 1'($urandom_range(0, 1));
      set_in(rs, rt, rsu, rtu, md, dv, br, ewe, ewr, eld, mwe, mwr);
      #1;
      fa = (rsu && ewe && ewr != 5'd0 && ewr == rs && !eld) ? 2'b01 :
           (rsu && mwe && mwr != 5'd0 && mwr == rs) ? 2'b10 : 2'b00;
      fb = (rtu && ewe && ewr != 5'd0 && ewr == rt && !eld) ? 2'b01 :
           (rtu && mwe && mwr != 5'd0 && mwr == rt) ? 2'b10 : 2'b00;
      lu = eld && ((rsu && ewe && ewr != 5'd0 && ewr == rs) || (rtu && ewe && ewr != 5'd0 && ewr == rt));
      for (int d = 0; d < 2; d++) begin
        ov = (d == 0) ? {hz0.pc_we, hz0.fd_we, hz0.de_we, hz0.fd_flush, hz0.de_bubble, hz0.em_bubble,
                         hz0.fwd_a_sel, hz0.fwd_b_sel, hz0.muldiv_busy}
                      : {hz1.pc_we, hz1.fd_we, hz1.de_we, hz1.fd_flush, hz1.de_bubble, hz1.em_bubble,
                         hz1.fwd_a_sel, hz1.fwd_b_sel, hz1.muldiv_busy};
        sv = (d == 0) ? hz0.stall_cycles : hz1.stall_cycles;
        mask = 11'h7FF;
        if (left[d] > 0) begin
          ev = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fa, fb, 1'b1};
          mask = 11'h7BF;
        end else if (lu) begin
          ev = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, fa, fb, 1'b0};
        end else begin
          ev = {1'b1, 1'b1, 1'b1, br, 1'b0, 1'b0, fa, fb, 1'b0};
        end
        checks++; if ((ov & mask) !== (ev & mask)) begin failures++; $display("FAIL rnd_ctrl dut%0d cyc%0d got=%03h want=%03h", d, c, ov & mask, ev & mask); end
        checks++; if (sv !== 32'(cnt[d])) begin failures++; $display("FAIL rnd_stall dut%0d cyc%0d got=%0d want=%0d", d, c, sv, cnt[d]); end
        stalled = (left[d] > 0) || lu;
        if (stalled && cnt[d] < 64'h0000_0000_FFFF_FFFF) cnt[d] = cnt[d] + 1;
        if (left[d] > 0) left[d] = left[d] - 1;
        else if (!lu && md) left[d] = (dv ? divn[d] : muln[d]) - 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    exp_stall = 32'd0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_div();
    test_mul_single();
    test_reset_mid_div();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
